// File: rtl/zap_fetch_buffer.sv
// Fetch-stage instruction FIFO between the I-cache and decode: Thumb half-word alignment, abort/breakpoint tagging, PC+4/PC+8.
// Optional build macro: ZAP_FETCH_BKPT_EN compiles in ARM/Thumb BKPT detection, which tags the entry as aborting.
module zap_fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_clear_from_writeback,
    input  logic                       i_clear_from_alu,
    input  logic                       i_clear_from_decode,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [31:0]                i_instruction,
    input  logic                       i_instr_abort,
    input  logic [31:0]                i_pc_ff,
    input  logic                       i_cpsr_ff_t,
    input  logic [1:0]                 i_taken,
    input  logic [32:0]                i_pred,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [31:0]                o_instruction,
    output logic                       o_instr_abort,
    output logic [31:0]                o_pc_ff,
    output logic [31:0]                o_pc_plus_8_ff,
    output logic [1:0]                 o_taken,
    output logic [32:0]                o_pred,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          sleep;

    logic [31:0] mem_instr [DEPTH];
    logic        mem_abort [DEPTH];
    logic [31:0] mem_pc    [DEPTH];
    logic [31:0] mem_pc8   [DEPTH];
    logic [1:0]  mem_taken [DEPTH];
    logic [32:0] mem_pred  [DEPTH];

    logic        clear;
    logic        push;
    logic        pop;
    logic [31:0] aligned_instr;
    logic [31:0] pc_plus_n;
    logic        bkpt_hit;
    logic        abort_tag;

    assign clear = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;

    // Handshakes are built from registered state only.
    assign o_ready = (count != FULL_COUNT) & ~sleep;
    assign o_valid = (count != '0);
    assign o_level = count;

    assign push = i_valid & o_ready & ~clear;
    assign pop  = o_valid & i_ready & ~clear;

    assign aligned_instr = i_pc_ff[1] ? {16'h0000, i_instruction[31:16]} : i_instruction;
    assign pc_plus_n     = i_pc_ff + (i_cpsr_ff_t ? 32'd4 : 32'd8);

`ifdef ZAP_FETCH_BKPT_EN
    logic [15:0] thumb_half;
    assign thumb_half = i_pc_ff[1] ? i_instruction[31:16] : i_instruction[15:0];
    // ARM BKPT: cond=1110, 0001_0010 imm12 0111 imm4. Thumb BKPT: 1011_1110 imm8.
    assign bkpt_hit = i_cpsr_ff_t ? (thumb_half[15:8] == 8'hBE)
                                  : ((i_instruction & 32'hFFF0_00F0) == 32'hE120_0070);
`else
    logic unused_bkpt_inputs;
    assign unused_bkpt_inputs = i_cpsr_ff_t;
    assign bkpt_hit = 1'b0;
`endif

    assign abort_tag = i_instr_abort | bkpt_hit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sleep  <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sleep  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (abort_tag) begin
                    sleep <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_abort[i] <= 1'b0;
                mem_pc[i]    <= '0;
                mem_pc8[i]   <= '0;
                mem_taken[i] <= '0;
                mem_pred[i]  <= '0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= aligned_instr;
            mem_abort[wr_ptr] <= abort_tag;
            mem_pc[wr_ptr]    <= i_pc_ff;
            mem_pc8[wr_ptr]   <= pc_plus_n;
            mem_taken[wr_ptr] <= i_taken;
            mem_pred[wr_ptr]  <= i_pred;
        end
    end

    // Head entry is presented straight from storage.
    assign o_instruction  = mem_instr[rd_ptr];
    assign o_instr_abort  = mem_abort[rd_ptr];
    assign o_pc_ff        = mem_pc[rd_ptr];
    assign o_pc_plus_8_ff = mem_pc8[rd_ptr];
    assign o_taken        = mem_taken[rd_ptr];
    assign o_pred         = mem_pred[rd_ptr];

endmodule

// File: tb/tb_zap_fetch_buffer.sv
// Bench for zap_fetch_buffer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_zap_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_wb = 1'b0, clr_alu = 1'b0, clr_dec = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_instruction = '0;
    logic        i_instr_abort = 1'b0;
    logic [31:0] i_pc_ff = '0;
    logic        i_t = 1'b0;
    logic [1:0]  i_taken = '0;
    logic [32:0] i_pred = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_instruction;
    logic        o_instr_abort;
    logic [31:0] o_pc_ff;
    logic [31:0] o_pc_plus_8_ff;
    logic [1:0]  o_taken;
    logic [32:0] o_pred;
    logic [2:0]  o_level;

    int checks = 0;
    int errors = 0;

    zap_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_clear_from_writeback(clr_wb), .i_clear_from_alu(clr_alu), .i_clear_from_decode(clr_dec),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(i_instruction), .i_instr_abort(i_instr_abort), .i_pc_ff(i_pc_ff),
        .i_cpsr_ff_t(i_t), .i_taken(i_taken), .i_pred(i_pred),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_instruction(o_instruction), .o_instr_abort(o_instr_abort), .o_pc_ff(o_pc_ff),
        .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_taken(o_taken), .o_pred(o_pred), .o_level(o_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        abort;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [1:0]  taken;
        logic [32:0] pred;
    } ent_t;

    ent_t q[$];
    bit   m_sleep = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bkpt(input logic [31:0] w, input logic [31:0] pc, input logic t);
`ifdef ZAP_FETCH_BKPT_EN
        logic [15:0] h;
        h = pc[1] ? w[31:16] : w[15:0];
        if (t) return h[15:8] == 8'hBE;
        return w[31:20] == 12'hE12 && w[7:4] == 4'h7;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: a plain queue updated with the FIFO rules at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_sleep = 1'b0;
        end else if (clr_wb || clr_alu || clr_dec) begin
            q.delete();
            m_sleep = 1'b0;
        end else begin
            bit do_pop, do_push;
            ent_t e;
            do_pop  = (q.size() != 0) && i_ready;
            do_push = i_valid && (q.size() < DEPTH) && !m_sleep;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.instr = i_pc_ff[1] ? (i_instruction >> 16) : i_instruction;
                e.abort = i_instr_abort | is_bkpt(i_instruction, i_pc_ff, i_t);
                e.pc    = i_pc_ff;
                e.pc8   = i_pc_ff + (i_t ? 32'd4 : 32'd8);
                e.taken = i_taken;
                e.pred  = i_pred;
                q.push_back(e);
                if (e.abort) m_sleep = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", 64'(o_valid), 64'(q.size() != 0));
            chk("m_ready", 64'(o_ready), 64'((q.size() != DEPTH) && !m_sleep));
            chk("m_level", 64'(o_level), 64'(q.size()));
            if (q.size() != 0) begin
                chk("m_instr", 64'(o_instruction), 64'(q[0].instr));
                chk("m_abort", 64'(o_instr_abort), 64'(q[0].abort));
                chk("m_pc",    64'(o_pc_ff),       64'(q[0].pc));
                chk("m_pc8",   64'(o_pc_plus_8_ff), 64'(q[0].pc8));
                chk("m_taken", 64'(o_taken),       64'(q[0].taken));
                chk("m_pred",  64'(o_pred),        64'(q[0].pred));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] w, input logic [31:0] pc, input logic t, input logic ab);
        i_valid = 1'b1; i_instruction = w; i_pc_ff = pc; i_t = t; i_instr_abort = ab;
        i_taken = pc[3:2]; i_pred = {pc[4], pc ^ 32'h5A5A_0000};
        step();
        i_valid = 1'b0; i_instr_abort = 1'b0; i_t = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_instr", 64'(o_instruction), 64'd0);
        chk("rst_pc8",   64'(o_pc_plus_8_ff), 64'd0);
        chk("rst_pred",  64'(o_pred), 64'd0);
        rst_n = 1'b1;
        step();

        // Fill then drain
        for (int k = 0; k < 4; k++) push_one(32'hE3A0_0000 | k, 32'(4 * k), 1'b0, 1'b0);
        chk("fill_level", 64'(o_level), 64'd4);
        chk("fill_ready", 64'(o_ready), 64'd0);
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc8", 64'(o_pc_plus_8_ff), 64'(8 + 4 * k));
            step();
        end
        i_ready = 1'b0;
        chk("drain_empty", 64'(o_valid), 64'd0);

        // Thumb alignment
        push_one(32'hABCD_1234, 32'h102, 1'b1, 1'b0);
        chk("thumb_instr", 64'(o_instruction), 64'h0000_ABCD);
        chk("thumb_pc8",   64'(o_pc_plus_8_ff), 64'h106);
        i_ready = 1'b1; step(); i_ready = 1'b0;

        // Abort puts the buffer to sleep
        push_one(32'hE1A0_0000, 32'h20, 1'b0, 1'b1);
        chk("abort_ready", 64'(o_ready), 64'd0);
        chk("abort_tag",   64'(o_instr_abort), 64'd1);
        chk("abort_pc",    64'(o_pc_ff), 64'h20);
        i_valid = 1'b1; i_instruction = 32'hE280_0001; i_pc_ff = 32'h24;
        i_ready = 1'b1; step(); i_ready = 1'b0;
        chk("abort_drained", 64'(o_valid), 64'd0);
        step(); step();
        chk("abort_ignored", 64'(o_level), 64'd0);
        chk("abort_asleep",  64'(o_ready), 64'd0);
        i_valid = 1'b0;
        clr_alu = 1'b1; step(); clr_alu = 1'b0;
        chk("abort_woken", 64'(o_ready), 64'd1);

        // Clear beats simultaneous push and pop
        for (int k = 0; k < 3; k++) push_one(32'hE1A0_1000 | k, 32'h200 + 32'(4 * k), 1'b0, 1'b0);
        chk("clr_level3", 64'(o_level), 64'd3);
        i_valid = 1'b1; i_ready = 1'b1; clr_dec = 1'b1; i_pc_ff = 32'h20C;
        step();
        i_valid = 1'b0; i_ready = 1'b0; clr_dec = 1'b0;
        chk("clr_level", 64'(o_level), 64'd0);
        chk("clr_valid", 64'(o_valid), 64'd0);
        chk("clr_ready", 64'(o_ready), 64'd1);

        // Breakpoint word
        push_one(32'hE120_0070, 32'h300, 1'b0, 1'b0);
`ifdef ZAP_FETCH_BKPT_EN
        chk("bkpt_tag",   64'(o_instr_abort), 64'd1);
        chk("bkpt_ready", 64'(o_ready), 64'd0);
`else
        chk("bkpt_tag",   64'(o_instr_abort), 64'd0);
        chk("bkpt_ready", 64'(o_ready), 64'd1);
`endif
        clr_wb = 1'b1; step(); clr_wb = 1'b0;

        // Sustained push+pop with pointer wrap, plus PC wrap-around
        i_ready = 1'b1; i_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            i_instruction = 32'h1111_0000 + 32'(k);
            i_pc_ff = (k == 6) ? 32'hFFFF_FFFC : 32'h400 + 32'(4 * k);
            i_taken = 2'(k); i_pred = {k[0], 32'hC0DE_0000 | 32'(k)};
            step();
        end
        i_valid = 1'b0;
        chk("stream_level", 64'(o_level), 64'd1);
        chk("wrap_pc8", 64'(o_pc_plus_8_ff), 64'h4);
        step();
        i_ready = 1'b0;

        // Async reset mid-state
        push_one(32'hE1A0_2000, 32'h40, 1'b0, 1'b0);
        push_one(32'hE1A0_3000, 32'h44, 1'b0, 1'b1);
        chk("pre_rst_level", 64'(o_level), 64'd2);
        chk("pre_rst_ready", 64'(o_ready), 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_level", 64'(o_level), 64'd0);
        chk("arst_ready", 64'(o_ready), 64'd1);
        chk("arst_pc",    64'(o_pc_ff), 64'd0);
        step();
        rst_n = 1'b1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zap_fetch_buffer.md
# zap_fetch_buffer

Parametrised fetch-stage instruction buffer between the I-cache and decode. Next-generation fetch stage: a DEPTH-entry FIFO with valid/ready flow control on both sides replaces the single-register, global-stall forwarding stage. Per entry it performs Thumb half-word alignment, breakpoint tagging and PC+4/PC+8 generation. After an abort is accepted, the buffer stops accepting new instructions until the pipeline is cleared.

## Interface
Parameters:
- DEPTH, 4, number of buffer entries; power of two, ≥ 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  one clock; reset is asynchronous and active-low.
- i_clear_from_writeback / i_clear_from_alu / i_clear_from_decode  in  1 each  flush requests, all of equal effect.
- i_valid  in  1  I-cache entry valid. An abort is presented with i_valid=1.
- o_ready  out  1  buffer can accept from the I-cache.
- i_instruction  in  32  raw 32-bit cache word.
- i_instr_abort  in  1  instruction abort for this word.
- i_pc_ff  in  32  PC of this word.
- i_cpsr_ff_t  in  1  Thumb state for this word.
- i_taken  in  2  branch-predictor state.
- i_pred  in  33  BTB prediction: bit 32 = made-prediction, bits 31:0 = address.
- o_valid  out  1  head entry valid toward decode.
- i_ready  in  1  decode accepts the head entry.
- o_instruction  out  32  aligned instruction.
- o_instr_abort  out  1  abort or breakpoint tag.
- o_pc_ff  out  32  entry PC.
- o_pc_plus_8_ff  out  32  PC+8 in ARM state, PC+4 in Thumb state.
- o_taken  out  2  predictor state.
- o_pred  out  33  prediction.
- o_level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage:
  - Circular array of DEPTH entries, with write pointer, read pointer and occupancy count (0..DEPTH).
  - Pointers wrap modulo DEPTH.
- Write (push):
  - Occurs when i_valid & o_ready & no clear input is active.
  - o_ready = (count != DEPTH) & ~sleep.
- Read (pop): occurs when o_valid & i_ready, where o_valid = (count != 0).
- Data path:
  - All o_* data outputs show the head entry directly from storage, with no extra register.
  - Instruction alignment: stored = i_pc_ff[1] ? i_instruction >> 16 : i_instruction.
  - PC+N: 32-bit modulo addition, so PC 0xFFFFFFFC + 8 = 0x00000004.
- Abort tag stored per entry: i_instr_abort OR breakpoint match (see Configuration).
- sleep flag:
  - Set on a push whose stored abort tag is 1.
  - While set, o_ready = 0. Entries already buffered, including the aborting one, still drain to decode.
  - Cleared only by a clear input or by reset.
- Clear (any of the three inputs):
  - Next edge: pointers = 0, count = 0, sleep = 0.
  - Clear has priority over a simultaneous push and pop; both are discarded.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- When full there is no bypass: o_ready = 0, and a pop in that cycle frees the slot for the next cycle.
- When empty there is no bypass: a pushed entry is first visible on the next cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - Pointers, count, sleep = 0.
  - All storage entries = 0, so every o_* data output = 0.
  - o_valid = 0, o_level = 0, o_ready = 1.
- Latency: push at edge N → o_valid = 1 with that entry's data after edge N, so decode can accept in cycle N+1.
- Throughput: 1 push and 1 pop per cycle sustained.
- o_ready and o_valid depend only on registered state; there is no combinational path from i_ready or i_valid.
- Reset asserted mid-burst: state clears immediately, with no clock required.

## Configuration
- ZAP_FETCH_BKPT_EN defined: breakpoint detection is compiled in. The abort tag is forced to 1 when:
  - ARM state (~i_cpsr_ff_t) and i_instruction matches BKPT; or
  - Thumb state and the selected half-word matches T_BKPT. The selected half-word is [31:16] if i_pc_ff[1], else [15:0].
  - A breakpoint match also sets sleep.
- ZAP_FETCH_BKPT_EN undefined: abort tag = i_instr_abort only, and the breakpoint comparators are absent.

## Test plan
- Fill/drain, DEPTH=4, i_ready=0: push 4 ARM words at PCs 0x0, 0x4, 0x8, 0xC → o_level=4, o_ready=0. Then i_ready=1 → outputs in order, o_pc_plus_8_ff = 0x8, 0xC, 0x10, 0x14.
- Thumb alignment: T=1, PC=0x102, word 0xABCD1234 → o_instruction=0x0000ABCD, o_pc_plus_8_ff=0x106.
- Abort sleep: push with i_instr_abort=1 at PC 0x20 → o_ready=0 on the next cycle. Further i_valid is ignored, the 0x20 entry drains with o_instr_abort=1, and o_ready stays 0 until i_clear_from_alu.
- Clear priority: count=3, and in one cycle i_valid=1, i_ready=1, i_clear_from_decode=1 → next cycle o_level=0, o_valid=0, o_ready=1.
- Breakpoint, with ZAP_FETCH_BKPT_EN: ARM word 0xE1200070, i_instr_abort=0 → o_instr_abort=1 and sleep set. Without the macro → o_instr_abort=0, o_ready stays 1.
- Async reset with count=2 and sleep=1, i_reset_n low between clock edges → o_valid=0, o_level=0, o_ready=1 immediately.
